// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command sequencer: registers operands into an attached ALU, captures the
// class-selected result. Define ALU_SEQ_TIMEOUT_EN to wait for matching class flags with a timeout.
module alu_cmd_sequencer #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned TIMEOUT_CYC = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_fun,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic [3:0]       rsp_class,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_fun,
   input  logic [WIDTH-1:0] alu_arith_out,
   input  logic [WIDTH-1:0] alu_logic_out,
   input  logic [WIDTH-1:0] alu_cmp_out,
   input  logic [WIDTH-1:0] alu_shift_out,
   input  logic             alu_carry_out,
   input  logic [3:0]       alu_flags
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]       alu_fun_q, alu_fun_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]       rsp_class_q, rsp_class_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_err_q, rsp_err_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_carry;
   logic [3:0]       exp_class;
   logic             class_ok;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   // The timeout depth only matters when the timeout feature is built in.
   logic timeout_unused;
   assign timeout_unused = ^TIMEOUT_CYC;
`endif

   // Gating with RST keeps cmd_ready low for the whole reset pulse.
   assign cmd_ready = (state_q == StIdle) && !RST;
   assign rsp_valid = (state_q == StResp);
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_class = rsp_class_q;
   assign rsp_err   = rsp_err_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_fun   = alu_fun_q;

   assign exp_class = 4'b0001 << alu_fun_q[3:2];
   assign class_ok  = (alu_flags == exp_class);

   always_comb begin
      sel_data  = alu_arith_out;
      sel_carry = 1'b0;
      unique case (alu_fun_q[3:2])
         2'b00: begin
            sel_data  = alu_arith_out;
            sel_carry = alu_carry_out;
         end
         2'b01:   sel_data = alu_logic_out;
         2'b10:   sel_data = alu_cmp_out;
         default: sel_data = alu_shift_out;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_fun_d   = alu_fun_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_class_d = rsp_class_q;
      rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready) begin
               alu_a_d   = cmd_a;
               alu_b_d   = cmd_b;
               alu_fun_d = cmd_fun;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StWait: begin
`ifdef ALU_SEQ_TIMEOUT_EN
            if (class_ok) begin
               rsp_data_d  = sel_data;
               rsp_carry_d = sel_carry;
               rsp_class_d = alu_flags;
               rsp_err_d   = 1'b0;
               state_d     = StResp;
            end else if (cnt_q == CntLast) begin
               rsp_data_d  = '0;
               rsp_carry_d = 1'b0;
               rsp_class_d = alu_flags;
               rsp_err_d   = 1'b1;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            rsp_data_d  = sel_data;
            rsp_carry_d = sel_carry;
            rsp_class_d = alu_flags;
            rsp_err_d   = !class_ok;
            state_d     = StResp;
`endif
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= '0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_class_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_fun_q   <= alu_fun_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_class_q <= rsp_class_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef ALU_SEQ_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a small ALU model, a transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_cmd_sequencer;
   localparam int W = 16;
   localparam int T = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [3:0]   cmd_fun = '0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         rsp_carry;
   logic [3:0]   rsp_class;
   logic         rsp_err;
   logic [W-1:0] alu_a, alu_b;
   logic [3:0]   alu_fun;
   logic [W-1:0] alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out;
   logic         alu_carry_out;
   logic [3:0]   alu_flags;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT_CYC(T)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_class(rsp_class), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
      .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out),
      .alu_cmp_out(alu_cmp_out), .alu_shift_out(alu_shift_out),
      .alu_carry_out(alu_carry_out), .alu_flags(alu_flags)
   );

   // Full 16-function ALU; returns {carry, result}.
   function automatic logic [W:0] alu_op(input logic [3:0] fun, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W-1:0] r;
      logic lt, gt;
      lt = fun[0] ? ($signed(a) < $signed(b)) : (a < b);
      gt = fun[0] ? ($signed(a) > $signed(b)) : (a > b);
      r = '0;
      case (fun)
         4'd0:  return {1'b0, a} + {1'b0, b};
         4'd1:  return {1'b0, a} - {1'b0, b};
         4'd2:  return {1'b0, a} + {1'b0, b} + 1'b1;
         4'd3:  return {1'b0, a} - {1'b0, b} - 1'b1;
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a ^ b;
         4'd7:  r = ~(a | b);
         4'd8, 4'd9, 4'd10, 4'd11: r = {{(W-3){1'b0}}, lt, gt, a == b};
         4'd12: r = a << b[3:0];
         4'd13: r = a >> b[3:0];
         4'd14: r = $signed(a) >>> b[3:0];
         default: r = {b[W-2:0], b[W-1]};
      endcase
      return {1'b0, r};
   endfunction

   // Function 1101 deliberately reports the wrong class.
   function automatic logic [3:0] ref_flags(input logic [3:0] fun);
      if (fun == 4'b1101) return 4'b0001;
      return 4'b0001 << fun[3:2];
   endfunction

   logic [W:0] op_ar, op_lo, op_cm, op_sh;
   always_comb begin
      op_ar = alu_op({2'b00, alu_fun[1:0]}, alu_a, alu_b);
      op_lo = alu_op({2'b01, alu_fun[1:0]}, alu_a, alu_b);
      op_cm = alu_op({2'b10, alu_fun[1:0]}, alu_a, alu_b);
      op_sh = alu_op({2'b11, alu_fun[1:0]}, alu_a, alu_b);
   end
   assign alu_arith_out = op_ar[W-1:0];
   assign alu_carry_out = op_ar[W];
   assign alu_logic_out = op_lo[W-1:0];
   assign alu_cmp_out   = op_cm[W-1:0];
   assign alu_shift_out = op_sh[W-1:0];
   assign alu_flags     = ref_flags(alu_fun);

   typedef struct packed {
      logic [W-1:0] data;
      logic         carry;
      logic [3:0]   cls;
      logic         err;
      logic [7:0]   lat;
   } exp_t;

   // Expected response of one command; lat is the edge after accept at which it appears.
   function automatic exp_t ref_rsp(input logic [3:0] fun, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      exp_t e;
      logic [W:0] r;
      r       = alu_op(fun, a, b);
      e.cls   = ref_flags(fun);
      e.err   = (e.cls != (4'b0001 << fun[3:2]));
      e.data  = r[W-1:0];
      e.carry = (fun[3:2] == 2'b00) ? r[W] : 1'b0;
      e.lat   = 8'd2;
`ifdef ALU_SEQ_TIMEOUT_EN
      if (e.err) begin
         e.data  = '0;
         e.carry = 1'b0;
         e.lat   = 8'(1 + T);
      end
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model state, advanced once per cycle at the falling edge.
   logic         m_busy = 1'b0;
   int           m_edges = 0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic [3:0]   m_fun = '0;
   exp_t         m_exp = '0;

   always @(negedge CLK) begin
      logic vexp;
      if (RST) begin
         chk("rst_cmd_ready", cmd_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_rsp_carry", rsp_carry, 0);
         chk("rst_rsp_class", rsp_class, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_alu_a", alu_a, 0);
         chk("rst_alu_b", alu_b, 0);
         chk("rst_alu_fun", alu_fun, 0);
         m_busy = 1'b0;
         m_a = '0;
         m_b = '0;
         m_fun = '0;
      end else begin
         if (m_busy) m_edges++;
         vexp = m_busy && (m_edges >= int'(m_exp.lat) + 1);
         chk("cmd_ready", cmd_ready, !m_busy);
         chk("rsp_valid", rsp_valid, vexp);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_fun", alu_fun, m_fun);
         if (vexp) begin
            chk("rsp_data", rsp_data, m_exp.data);
            chk("rsp_carry", rsp_carry, m_exp.carry);
            chk("rsp_class", rsp_class, m_exp.cls);
            chk("rsp_err", rsp_err, m_exp.err);
         end
         if (!m_busy && cmd_valid) begin
            m_a     = cmd_a;
            m_b     = cmd_b;
            m_fun   = cmd_fun;
            m_exp   = ref_rsp(cmd_fun, cmd_a, cmd_b);
            m_busy  = 1'b1;
            m_edges = 0;
         end else if (vexp && rsp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   logic [3:0]   d_fun[4];
   logic [W-1:0] d_a[4], d_b[4];
   logic [W-1:0] r_data[4];
   logic [3:0]   r_cls[4];
   logic         r_err[4], r_carry[4];
   int           r_cyc[4], a_cyc[4];
   int           r_hold, bad_ready;

   // Issue n directed commands back to back; hold = valid cycles to stall each response.
   task automatic do_cmds(input int n, input int hold);
      int acc = 0, got = 0, cyc = 0, vcnt = 0;
      bad_ready = 0;
      r_hold = 0;
      @(posedge CLK); #2;
      cmd_valid = 1'b1;
      cmd_fun = d_fun[0];
      cmd_a = d_a[0];
      cmd_b = d_b[0];
      rsp_ready = (hold == 0);
      while (got < n && cyc < 100) begin
         @(negedge CLK);
         cyc++;
         if (rsp_valid && cmd_ready) bad_ready++;
         if (rsp_valid) begin
            if (rsp_ready) begin
               r_data[got] = rsp_data;
               r_cls[got] = rsp_class;
               r_err[got] = rsp_err;
               r_carry[got] = rsp_carry;
               r_cyc[got] = cyc;
               r_hold = vcnt;
               got++;
               vcnt = 0;
            end else begin
               vcnt++;
            end
         end
         if (cmd_valid && cmd_ready) begin
            a_cyc[acc] = cyc;
            acc++;
         end
         if (got < n) begin
            @(posedge CLK); #2;
            if (acc < n) begin
               cmd_fun = d_fun[acc];
               cmd_a = d_a[acc];
               cmd_b = d_b[acc];
            end else begin
               cmd_valid = 1'b0;
               cmd_fun = 4'($urandom);
               cmd_a = W'($urandom);
               cmd_b = W'($urandom);
            end
            rsp_ready = (vcnt >= hold);
         end
      end
      chk("directed_completed", got, n);
      cmd_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return W'(1) << (W - 1);
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int seen;
      repeat (3) @(negedge CLK);
      #1;
      chk("reset_cmd_ready_literal", cmd_ready, 0);
      chk("reset_alu_fun_literal", alu_fun, 0);
      @(posedge CLK); #2;
      RST = 1'b0;

      d_fun[0] = 4'b0000; d_a[0] = 16'd15; d_b[0] = 16'd15;
      do_cmds(1, 0);
      chk("add_data", r_data[0], 30);
      chk("add_class", r_cls[0], 4'b0001);
      chk("add_err", r_err[0], 0);
      chk("add_carry", r_carry[0], 0);
      chk("add_latency", r_cyc[0] - a_cyc[0], 3);

      d_fun[0] = 4'b0001; d_a[0] = 16'd65;    d_b[0] = 16'd15;
      d_fun[1] = 4'b0110; d_a[1] = 16'hFFFF;  d_b[1] = 16'hFFFC;
      do_cmds(2, 0);
      chk("b2b_data0", r_data[0], 50);
      chk("b2b_class0", r_cls[0], 4'b0001);
      chk("b2b_data1", r_data[1], 3);
      chk("b2b_class1", r_cls[1], 4'b0010);
      chk("b2b_accept_gap", a_cyc[1] - a_cyc[0], 4);

      d_fun[0] = 4'b1010; d_a[0] = 16'd8; d_b[0] = 16'd5;
      do_cmds(1, 5);
      chk("stall_data", r_data[0], 2);
      chk("stall_class", r_cls[0], 4'b0100);
      chk("stall_cycles", r_hold, 5);
      chk("stall_cmd_ready_low", bad_ready, 0);

      d_fun[0] = 4'b1101; d_a[0] = 16'h00F0; d_b[0] = 16'd4;
      do_cmds(1, 0);
      chk("badclass_err", r_err[0], 1);
      chk("badclass_class", r_cls[0], 4'b0001);
`ifdef ALU_SEQ_TIMEOUT_EN
      chk("badclass_data", r_data[0], 0);
      chk("badclass_latency", r_cyc[0] - a_cyc[0], 2 + T);
`else
      chk("badclass_data", r_data[0], 16'h000F);
      chk("badclass_latency", r_cyc[0] - a_cyc[0], 3);
`endif

      @(posedge CLK); #2;
      cmd_valid = 1'b1; cmd_fun = 4'b1100; cmd_a = 16'd8; cmd_b = 16'd1;
      @(negedge CLK);
      chk("midrst_accept_ready", cmd_ready, 1);
      @(posedge CLK); #2;
      cmd_valid = 1'b0;
      @(posedge CLK); #2;
      RST = 1'b1;
      #1;
      chk("midrst_alu_a_async", alu_a, 0);
      chk("midrst_alu_fun_async", alu_fun, 0);
      chk("midrst_cmd_ready_async", cmd_ready, 0);
      chk("midrst_rsp_valid_async", rsp_valid, 0);
      @(posedge CLK); #2;
      RST = 1'b0;
      seen = 0;
      @(negedge CLK);
      chk("midrst_ready_after_release", cmd_ready, 1);
      repeat (6) begin
         if (rsp_valid) seen++;
         @(negedge CLK);
      end
      chk("midrst_no_response", seen, 0);
      d_fun[0] = 4'b1111; d_a[0] = 16'd0; d_b[0] = 16'd7;
      do_cmds(1, 0);
      chk("midrst_next_data", r_data[0], 14);
      chk("midrst_next_class", r_cls[0], 4'b1000);
      chk("midrst_next_err", r_err[0], 0);

      for (int i = 0; i < 3000; i++) begin
         @(posedge CLK); #2;
         RST = ($urandom_range(0, 199) == 0);
         cmd_valid = ($urandom_range(0, 9) < 6);
         cmd_fun = 4'($urandom);
         cmd_a = rnd_operand();
         cmd_b = rnd_operand();
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge CLK); #2;
      RST = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (T + 8) @(negedge CLK);
      chk("drain_idle", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL match the attached ALU.
REQ-002 Parameter TIMEOUT_CYC, default 8, maximum WAIT edges before timeout; used only when ALU_SEQ_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid in 1, cmd_ready out 1, cmd_fun in 4, cmd_a in WIDTH, cmd_b in WIDTH: command channel.
REQ-006 rsp_valid out 1, rsp_ready in 1, rsp_data out WIDTH, rsp_carry out 1, rsp_class out 4, rsp_err out 1: response channel.
REQ-007 alu_a out WIDTH, alu_b out WIDTH, alu_fun out 4: registered drive into the ALU.
REQ-008 alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out in WIDTH each; alu_carry_out in 1; alu_flags in 4: ALU results and one-hot class flags.

Function
REQ-009 FSM states IDLE, ISSUE, WAIT, RESP; IDLE is the only state with cmd_ready=1.
REQ-010 On a handshake (cmd_valid & cmd_ready) at edge E0: alu_a/alu_b/alu_fun SHALL load cmd_a/cmd_b/cmd_fun; state -> ISSUE.
REQ-011 alu_a/alu_b/alu_fun SHALL hold stable from E0 until the next accepted command, including through reset release.
REQ-012 ISSUE -> WAIT unconditionally at E1; WAIT edge counter SHALL clear on WAIT entry.
REQ-013 Expected class = one-hot of alu_fun[3:2]: 00->4'b0001, 01->4'b0010, 10->4'b0100, 11->4'b1000.
REQ-014 Result select by alu_fun[3:2]: arith, logic, cmp, shift output; rsp_carry = alu_carry_out for arith class, else 0.
REQ-015 On capture: rsp_data = selected result, rsp_class = alu_flags, rsp_err = (alu_flags != expected); state -> RESP; rsp_valid=1.
REQ-016 In RESP, rsp_* SHALL hold stable while rsp_ready=0; on rsp_valid & rsp_ready, rsp_valid -> 0 and state -> IDLE on that edge.
REQ-017 Minimum latency: rsp_valid high in the cycle after E2 (two edges after accept); throughput one command per 4 cycles with rsp_ready=1.
REQ-018 cmd_valid while not in IDLE SHALL be ignored; cmd fields sampled only at the handshake edge.
REQ-019 Arithmetic is the ALU's; the sequencer SHALL NOT modify, truncate or sign-extend result data.

Reset
REQ-020 RST=1 SHALL immediately force state IDLE, counter 0, and every output to 0 (cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_class, rsp_err, alu_a, alu_b, alu_fun).
REQ-021 cmd_ready SHALL rise in the first cycle after RST deasserts.
REQ-022 Reset during ISSUE/WAIT/RESP SHALL discard the operation; no response SHALL be produced for it.

Configuration
REQ-023 Macro ALU_SEQ_TIMEOUT_EN.
REQ-024 Defined: capture at the first WAIT edge (E2 or later) where alu_flags == expected; if no match by edge E(1+TIMEOUT_CYC), go to RESP with rsp_data=0, rsp_carry=0, rsp_class=alu_flags, rsp_err=1.
REQ-025 Undefined: capture unconditionally at E2 per REQ-015; no counter logic SHALL be synthesised.

Verification
REQ-026 cmd_fun=0000, a=15, b=15, rsp_ready=1 -> rsp_data=30, rsp_class=0001, rsp_err=0, rsp_carry=0, rsp_valid after 2 edges.
REQ-027 Back-to-back: fun=0001 a=65 b=15, then fun=0110 a=16'hFFFF b=16'hFFFC -> rsp_data 50 (class 0001), then 3 (class 0010); second accept 4 cycles after first.
REQ-028 fun=1010 a=8 b=5, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=2, rsp_class=0100 stable throughout; cmd_ready=0 until handshake.
REQ-029 Model ALU drives alu_flags=0001 for fun=1101 -> without macro: rsp_err=1 at E2; with macro: rsp_err=1, rsp_data=0 after TIMEOUT_CYC WAIT edges.
REQ-030 RST pulse during WAIT of fun=1100 a=8 -> all outputs 0 asynchronously, no rsp_valid; next command fun=1111 b=7 -> rsp_data=14, class 1000.
